cpu_reset_sequencer: RTL
========================

# cpu_reset_sequencer

Generates the stretched, clean CPU reset for the game core and is the consumer of the watchdog's reset request. It accepts power-on/system reset and the watchdog's `WDRESETn` level, holds the CPU in reset for a fixed number of clocks, and drives `WDCLRn` to clear the watchdog counter while the CPU is held, so that the watchdog cannot re-trip on stale counts. It also counts watchdog trips for the debug/OSD path.

## Interface
Parameters:
- `HOLD_CYCLES`, 64: number of clocks the CPU reset is held after any reset cause; legal range 2..65536.
- `MAX_TRIPS`, 4: trip count at which lockout occurs (only with `WDRST_TRIP_LOCKOUT_EN`); legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high system reset.
- `WDRESETn`  in  1  watchdog reset request, active low; asynchronous to `clk`, so it is synchronized internally.
- `CPU_RESETn`  out  1  CPU reset, active low, registered.
- `WDCLRn`  out  1  watchdog clear, active low, registered; ORed externally into the watchdog's `WDOGn` clear.
- `trip_count`  out  8  number of watchdog trips since `reset`; saturates at 255.
- `locked`  out  1  lockout indicator; tied to 0 when the macro is not defined.

## Operation
- Synchronizer: two flops `wd_s1` → `wd_s2`, both reset to 1. Every decision uses `wd_s2` only.
- Hold counter width is `$clog2(HOLD_CYCLES)`. It is cleared on every entry to HOLD.
- States:
  - HOLD: `CPU_RESETn`=0, `WDCLRn`=0. The counter increments each clock. When the counter equals `HOLD_CYCLES-1`, go to ARM.
  - ARM: `CPU_RESETn`=0, `WDCLRn`=1. When `wd_s2`=1, go to RUN; otherwise stay in ARM indefinitely.
  - RUN: `CPU_RESETn`=1, `WDCLRn`=1. When `wd_s2`=0, go to HOLD and increment `trip_count` (saturating at 255).
  - LOCK (macro only): `CPU_RESETn`=0, `WDCLRn`=0, `locked`=1. The only exit is `reset`.
- A trip is detected only in RUN. `WDRESETn` lows seen in HOLD or ARM are ignored and are not counted.
- Outputs are decoded from the state and registered.

## Timing
- While `reset`=1 and on the first clock after it falls:
  - state=HOLD, counter=0
  - `CPU_RESETn`=0, `WDCLRn`=0
  - `trip_count`=0, `locked`=0
  - `wd_s1`=`wd_s2`=1
- Release after reset: `CPU_RESETn` rises exactly `HOLD_CYCLES+1` clocks after the first clock with `reset`=0, provided `wd_s2`=1 during ARM.
- Trip latency: `WDRESETn` sampled low at edge N gives `wd_s2`=0 after edge N+1, state=HOLD after edge N+2, and `CPU_RESETn`=0 and `WDCLRn`=0 visible after edge N+3.
- `trip_count` updates on the same edge as the RUN→HOLD transition.
- A `WDRESETn` low pulse shorter than one clock may be missed. This is acceptable because the watchdog holds the level until it is cleared.
- `reset` asserted in any state, including LOCK, forces HOLD on the next edge and clears the counter, `trip_count` and `locked`. `reset` has priority over every other event.
- If `wd_s2`=0 and the hold counter is at terminal count in the same cycle, the transition is still HOLD→ARM; ARM then waits for `wd_s2`=1.
- `HOLD_CYCLES`=2 gives exactly 2 clocks in HOLD.

## Configuration
- `WDRST_TRIP_LOCKOUT_EN` defined:
  - On the RUN→HOLD transition where the incremented `trip_count` equals `MAX_TRIPS`, the next state is LOCK instead of HOLD.
  - LOCK holds the CPU and the watchdog cleared permanently, with `locked`=1, until `reset`.
- Not defined:
  - LOCK state is absent and `locked` is constant 0.
  - Trips always return to HOLD, and `trip_count` saturates at 255 without any effect on behaviour.

## Test plan
- Power-up: `HOLD_CYCLES`=64, `reset` high for 5 clocks, `WDRESETn`=1.
  - `CPU_RESETn`=0 and `WDCLRn`=0 for 64 clocks after `reset` falls.
  - `WDCLRn` rises at clock 64 and `CPU_RESETn` rises at clock 65.
- Single trip: in RUN, drive `WDRESETn`=0 at edge N.
  - `CPU_RESETn`=0 after edge N+3 and `trip_count`=1.
  - `WDCLRn` stays low for 64 clocks; the bench then returns `WDRESETn`=1 and `CPU_RESETn` recovers.
- ARM wait: hold `WDRESETn`=0 throughout HOLD and 10 extra clocks.
  - `CPU_RESETn` stays 0 and `trip_count` stays 0.
  - `CPU_RESETn` rises 3 clocks after `WDRESETn` returns high.
- Mid-hold reset: assert `reset` at hold count 30.
  - Counter restarts and release occurs 65 clocks after `reset` falls; `trip_count`=0.
- Lockout (macro defined, `MAX_TRIPS`=4): force 4 trips.
  - After the 4th trip: `locked`=1 and `CPU_RESETn`=0 for at least 1000 clocks.
  - `reset` clears `locked` and `trip_count`.
- Saturation (macro undefined): force 260 trips with `HOLD_CYCLES`=2.
  - `trip_count`=255, `locked`=0, and the CPU continues to recover after each trip.

Source files
------------

// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer: stretched CPU reset and watchdog clear; optional trip lockout under WDRST_TRIP_LOCKOUT_EN
module cpu_reset_sequencer #(
  parameter int HOLD_CYCLES = 64,
  parameter int MAX_TRIPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       WDRESETn,
  output logic       CPU_RESETn,
  output logic       WDCLRn,
  output logic [7:0] trip_count,
  output logic       locked
);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);
`ifdef WDRST_TRIP_LOCKOUT_EN
  typedef enum logic [1:0] {HOLD, ARM, RUN, LOCK} state_t;
`else
  typedef enum logic [1:0] {HOLD, ARM, RUN} state_t;
`endif
  state_t state, next, trip_next;
  logic [CW-1:0] cnt;
  logic wd_s1, wd_s2;
  logic [7:0] trip_inc;
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 65536 || MAX_TRIPS < 1 || MAX_TRIPS > 255) begin : g_bad_param
    $error("cpu_reset_sequencer: parameter out of range");
  end
  assign trip_inc = trip_count == 8'hff ? trip_count : trip_count + 8'd1;
`ifdef WDRST_TRIP_LOCKOUT_EN
  assign trip_next = trip_inc == 8'(MAX_TRIPS) ? LOCK : HOLD;
`else
  assign trip_next = HOLD;
`endif
  always_comb begin
    next = state == HOLD ? (cnt == TERM ? ARM : HOLD)
         : state == ARM  ? (wd_s2 ? RUN : ARM)
         : state == RUN  ? (wd_s2 ? RUN : trip_next)
         : state;
  end
  // the counter sits at zero outside HOLD, so every entry to HOLD starts from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      cnt        <= '0;
      wd_s1      <= 1'b1;
      wd_s2      <= 1'b1;
      trip_count <= '0;
      CPU_RESETn <= 1'b0;
      WDCLRn     <= 1'b0;
    end else begin
      state      <= next;
      cnt        <= state == HOLD ? cnt + 1'b1 : '0;
      wd_s1      <= WDRESETn;
      wd_s2      <= wd_s1;
      trip_count <= state == RUN && !wd_s2 ? trip_inc : trip_count;
      CPU_RESETn <= state == RUN;
      WDCLRn     <= state == ARM || state == RUN;
    end
  end
`ifdef WDRST_TRIP_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (reset) locked <= 1'b0;
    else locked <= state == LOCK;
  end
`else
  assign locked = 1'b0;
`endif
endmodule
